// File: rtl/display_driver_pkg.sv
// Shared types and width helpers for the HUB75 display driver blocks.
package display_driver_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    BLANK = 3'd3,
    LATCH = 3'd4
  } dd_state_e;

  // Row address width; a single-row panel still gets a 1-bit field.
  function automatic int unsigned row_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Plane index width; a single-plane pixel still gets a 1-bit field.
  function automatic int unsigned plane_width(input int unsigned bitwidth);
    return (bitwidth > 1) ? $clog2(bitwidth) : 1;
  endfunction

  // Display timer width, wide enough for the longest plane on-time.
  function automatic int unsigned timer_width(input int unsigned base_time,
                                              input int unsigned bitwidth);
    int unsigned w;
    w = $clog2((base_time << (bitwidth - 1)) + 1);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/display_driver_bcm_timer.sv
// Binary-coded-modulation on-time counter: load, decrement while displaying, zero flags.
module display_driver_bcm_timer #(
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             zero_next_c_o
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  // Next count: clear beats load beats decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o        = (count_q == '0);
  assign zero_next_c_o = (count_d == '0);

endmodule

// File: rtl/display_driver_row_sequencer.sv
// Scan/BCM sequencer: orders (row, plane) loads, handshakes with the row loader,
// and drives latch, output-enable and row address with weighted on-times.
module display_driver_row_sequencer
  import display_driver_pkg::*;
#(
  parameter int unsigned rows         = 16,
  parameter int unsigned bitwidth     = 8,
  parameter int unsigned base_time    = 32,
  parameter int unsigned blank_cycles = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  output logic                          load_o,
  input  logic                          complete_i,
  output logic [row_width(rows)-1:0]     load_row_o,
  output logic [plane_width(bitwidth)-1:0] load_plane_o,
  output logic                          latch_o,
  output logic                          oe_n_o,
  output logic [row_width(rows)-1:0]     row_o,
  output logic                          frame_start_o
);

  localparam int unsigned RW  = row_width(rows);
  localparam int unsigned PW  = plane_width(bitwidth);
  localparam int unsigned TW  = timer_width(base_time, bitwidth);
  localparam int unsigned BCW = (blank_cycles > 1) ? $clog2(blank_cycles) : 1;

  dd_state_e       state_q, state_d;
  logic            load_q, load_d;
  logic            latch_q, latch_d;
  logic            oe_n_q, oe_n_d;
  logic            fs_q, fs_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   load_row_q, load_row_d;
  logic [PW-1:0]   load_plane_q, load_plane_d;
  logic [BCW-1:0]  blank_q, blank_d;
  logic            timer_load, timer_clr;
  logic            timer_zero, timer_zero_next;
  logic [TW-1:0]   bcm_val;

  // On-time for the plane about to be latched.
  assign bcm_val = TW'(base_time) << load_plane_q;

  display_driver_bcm_timer #(
    .width(TW)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (timer_clr),
    .load_i       (timer_load),
    .load_val_i   (bcm_val),
    .dec_i        (~oe_n_q),
    .zero_o       (timer_zero),
    .zero_next_c_o(timer_zero_next)
  );

  // Next-state, pointer advance and registered-output next values.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    load_row_d   = load_row_q;
    load_plane_d = load_plane_q;
    blank_d      = blank_q;
    timer_load   = 1'b0;
    timer_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) state_d = LOAD;
      end
      LOAD: begin
        if (complete_i) state_d = WAIT;
      end
      WAIT: begin
        if (timer_zero) begin
          state_d = BLANK;
          blank_d = BCW'(blank_cycles - 1);
        end
      end
      BLANK: begin
        if (blank_q == '0) begin
          state_d    = LATCH;
          row_d      = load_row_q;
          timer_load = 1'b1;
          if (load_plane_q == PW'(bitwidth - 1)) begin
            load_plane_d = '0;
            if (load_row_q == RW'(rows - 1)) load_row_d = '0;
            else                             load_row_d = load_row_q + RW'(1);
          end else begin
            load_plane_d = load_plane_q + PW'(1);
          end
        end else begin
          blank_d = blank_q - BCW'(1);
        end
      end
      LATCH: begin
        state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping enable aborts everything and rewinds to the first pair.
    if (!enable_i) begin
      state_d      = IDLE;
      row_d        = '0;
      load_row_d   = '0;
      load_plane_d = '0;
      timer_load   = 1'b0;
      timer_clr    = 1'b1;
    end

    load_d  = (state_d == LOAD);
    latch_d = (state_d == LATCH);
    fs_d    = latch_d && (load_row_q == '0) && (load_plane_q == '0);
    oe_n_d  = !(((state_d == LOAD) || (state_d == WAIT)) && !timer_zero_next);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      load_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      fs_q         <= 1'b0;
      row_q        <= '0;
      load_row_q   <= '0;
      load_plane_q <= '0;
      blank_q      <= '0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      fs_q         <= fs_d;
      row_q        <= row_d;
      load_row_q   <= load_row_d;
      load_plane_q <= load_plane_d;
      blank_q      <= blank_d;
    end
  end

  assign load_o        = load_q;
  assign latch_o       = latch_q;
  assign oe_n_o        = oe_n_q;
  assign frame_start_o = fs_q;
  assign row_o         = row_q;
  assign load_row_o    = load_row_q;
  assign load_plane_o  = load_plane_q;

endmodule

// File: tb/tb_display_driver_row_sequencer.sv
// Bench for the row sequencer: loader BFM, latch scoreboard, hand-written corner sequences.
module tb_display_driver_row_sequencer;

  localparam int unsigned ROWS  = 2;
  localparam int unsigned BW    = 2;
  localparam int unsigned BASE  = 4;
  localparam int unsigned BLANK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic       load_o;
  logic       complete_i;
  logic [0:0] load_row_o;
  logic [0:0] load_plane_o;
  logic       latch_o;
  logic       oe_n_o;
  logic [0:0] row_o;
  logic       frame_start_o;

  logic bfm_c = 1'b0;
  logic spur_c = 1'b0;
  assign complete_i = bfm_c | spur_c;

  int  k_cyc   = 3;
  bit  hold2   = 1'b0;
  bit  spur_en = 1'b0;
  bit  mon_en  = 1'b0;
  int  oe_cnt  = 0;
  int  checks  = 0;
  int  errors  = 0;

  typedef struct {
    logic row;
    logic fs;
    logic nrow;
    logic nplane;
    int   on_prev;
  } exp_t;

  exp_t tbl[5];
  exp_t sb[$];

  display_driver_row_sequencer #(
    .rows(ROWS), .bitwidth(BW), .base_time(BASE), .blank_cycles(BLANK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .load_o       (load_o),
    .complete_i   (complete_i),
    .load_row_o   (load_row_o),
    .load_plane_o (load_plane_o),
    .latch_o      (latch_o),
    .oe_n_o       (oe_n_o),
    .row_o        (row_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Loader model: pulses complete K cycles into a load, optionally held one extra cycle.
  initial begin
    int  cnt;
    bit  pend;
    cnt  = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bfm_c = 1'b0;
      if (pend) begin
        bfm_c = 1'b1;
        pend  = 1'b0;
      end else if (load_o) begin
        cnt++;
        if (cnt >= k_cyc) begin
          bfm_c = 1'b1;
          cnt   = 0;
          pend  = hold2;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Spurious completes whenever no load is requested.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      spur_c = spur_en && !load_o && enable_i;
    end
  end

  // Monitor: accumulate on-time, compare each latch against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!enable_i || rst) oe_cnt = 0;
      else if (!oe_n_o)     oe_cnt++;
      if (mon_en && latch_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_latch: row %0d with empty scoreboard at %0t", row_o, $time);
        end else begin
          e = sb.pop_front();
          chk("latch_row",        row_o,         e.row);
          chk("latch_frame_start", frame_start_o, e.fs);
          chk("next_load_row",    load_row_o,    e.nrow);
          chk("next_load_plane",  load_plane_o,  e.nplane);
          chk("prev_on_time",     oe_cnt,        e.on_prev);
          oe_cnt = 0;
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d latches outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic stop_run();
    @(posedge clk);
    #1;
    enable_i = 1'b0;
    spur_en  = 1'b0;
    hold2    = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // One full frame plus wrap, from a fresh enable.
  task automatic run_table(input int k, input bit h, input bit sp);
    k_cyc   = k;
    hold2   = h;
    spur_en = sp;
    for (int i = 0; i < 5; i++) sb.push_back(tbl[i]);
    #1;
    enable_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_load",       load_o,       1);
    chk("first_load_row",   load_row_o,   0);
    chk("first_load_plane", load_plane_o, 0);
    chk("first_load_blank", oe_n_o,       1);
    drain(800);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8};

    rst      = 1'b1;
    enable_i = 1'b1;

    // Reset held with enable high keeps everything quiet.
    repeat (5) begin
      @(negedge clk);
      chk("rst_oe_n",  oe_n_o,  1);
      chk("rst_load",  load_o,  0);
      chk("rst_latch", latch_o, 0);
      chk("rst_row",   row_o,   0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_o && n < 2);
    chk("load_after_rst", load_o, 1);

    // First load handshake, blanking and plane-0 on-time.
    n = 0;
    while (!complete_i && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("complete_seen",     complete_i, 1);
    chk("load_with_complete", load_o,    1);
    @(negedge clk);
    chk("load_drop",  load_o, 0);
    chk("wait_blank", oe_n_o, 1);
    repeat (2) begin
      @(negedge clk);
      chk("blank_latch", latch_o, 0);
      chk("blank_oe_n",  oe_n_o,  1);
    end
    @(negedge clk);
    chk("latch_pulse", latch_o,       1);
    chk("latch_fs",    frame_start_o, 1);
    chk("latch_row0",  row_o,         0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("plane0_on", oe_n_o, 0);
    end
    @(negedge clk);
    chk("plane0_off", oe_n_o, 1);

    stop_run();
    mon_en = 1'b1;

    // Fast loader, then slow loader (longer than any on-time).
    run_table(3, 1'b0, 1'b0);
    stop_run();
    run_table(20, 1'b0, 1'b0);

    // Drop enable mid-load.
    @(posedge clk);
    #1;
    chk("load_before_drop", load_o, 1);
    enable_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_load", load_o, 0);
    chk("abort_oe_n", oe_n_o, 1);
    chk("abort_row",  load_row_o, 0);
    repeat (2) @(posedge clk);

    // Restart from (0,0), then spurious and stretched completes.
    run_table(3, 1'b0, 1'b0);
    stop_run();
    run_table(3, 1'b1, 1'b1);
    stop_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
